// File: rtl/toast_loader_pkg.sv
// Shared types and constants for the boot loader: FSM states, lane count, length width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package toast_loader_pkg;

    localparam int unsigned LANES     = 4;
    localparam int unsigned LANE_W    = 2;
    localparam int unsigned LEN_W     = 16;
    localparam logic [3:0]  WR_EN_ALL = 4'hF;

    typedef enum logic [2:0] {
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/toast_byte_packer.sv
// Packs little-endian bytes into 32-bit words; lane k lands in bits [8k+7:8k].
// Latency: word and word-valid pulse appear the cycle after the 4th byte is accepted.
// Backpressure: none; every asserted byte_vld_i is consumed.
module toast_byte_packer
    import toast_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic        last_lane_o,
    output logic        word_vld_o,
    output logic [31:0] word_o
);

    logic [LANE_W-1:0] lane_q;
    logic [23:0]       asm_q;
    logic [31:0]       word_q;
    logic              word_vld_q;

    assign last_lane_o = (lane_q == LANE_W'(LANES - 1));
    assign word_vld_o  = word_vld_q;
    assign word_o      = word_q;

    // Collect the lower three lanes, then emit the full word with a one-cycle pulse.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            lane_q     <= '0;
            asm_q      <= '0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
        end else begin
            word_vld_q <= 1'b0;
            if (byte_vld_i) begin
                lane_q <= lane_q + LANE_W'(1);
                case (lane_q)
                    2'd0:    asm_q[7:0]   <= byte_i;
                    2'd1:    asm_q[15:8]  <= byte_i;
                    2'd2:    asm_q[23:16] <= byte_i;
                    default: begin
                        word_q     <= {byte_i, asm_q};
                        word_vld_q <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/toast_boot_loader.sv
// Loads a length-framed byte image into memory as 32-bit words, holding the core in reset until done.
// Latency: write strobe one cycle after a word's 4th byte; done/error one cycle after the deciding byte.
// Backpressure: rx_ready_o high in every loading state (one byte per cycle), low in DONE/ERR.
// Optional trailing XOR checksum byte enabled by defining TOAST_LOADER_CHECKSUM_EN.
module toast_boot_loader
    import toast_loader_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 4096,
    parameter logic [31:0] LOAD_BASE = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [3:0]  mem_wr_byte_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wr_data_o,
    output logic        core_resetn_o,
    output logic        done_o,
    output logic        error_o
);

    localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(MEM_DEPTH);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   word_idx_q;
    logic [31:0]        addr_q;
    logic               xfer;
    logic               data_xfer;
    logic               last_lane;
    logic               last_word;
    logic               word_vld;
    logic [31:0]        word;
    logic [LEN_W-1:0]   len_full;
`ifdef TOAST_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q;
`endif

    assign rx_ready_o = (state_q != ST_DONE) && (state_q != ST_ERR);
    assign xfer       = rx_valid_i && rx_ready_o;
    assign data_xfer  = xfer && (state_q == ST_DATA);
    assign len_full   = {rx_data_i, len_q[7:0]};
    assign last_word  = ((word_idx_q + LEN_W'(1)) == len_q);

    toast_byte_packer u_packer (
        .clk_i       (clk_i),
        .resetn_i    (resetn_i),
        .byte_vld_i  (data_xfer),
        .byte_i      (rx_data_i),
        .last_lane_o (last_lane),
        .word_vld_o  (word_vld),
        .word_o      (word)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) state_q <= ST_LEN_LO;
        else           state_q <= state_d;
    end

    // Next-state: length check, word countdown, optional checksum verdict.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LEN_LO: if (xfer) state_d = ST_LEN_HI;
            ST_LEN_HI: begin
                if (xfer) begin
                    if ({1'b0, len_full} > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else if (len_full == '0) begin
`ifdef TOAST_LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (data_xfer && last_lane && last_word) begin
`ifdef TOAST_LOADER_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef TOAST_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (xfer) state_d = (rx_data_i == csum_q) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    // Capture the two length bytes.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            len_q <= '0;
        end else if (xfer && (state_q == ST_LEN_LO)) begin
            len_q[7:0] <= rx_data_i;
        end else if (xfer && (state_q == ST_LEN_HI)) begin
            len_q[15:8] <= rx_data_i;
        end
    end

    // Latch the write address alongside the word being completed, then advance the index.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            word_idx_q <= '0;
            addr_q     <= '0;
        end else if (data_xfer && last_lane) begin
            addr_q     <= LOAD_BASE + {14'd0, word_idx_q, 2'b00};
            word_idx_q <= word_idx_q + LEN_W'(1);
        end
    end

`ifdef TOAST_LOADER_CHECKSUM_EN
    // Running XOR over data bytes only.
    always_ff @(posedge clk_i) begin
        if (!resetn_i)      csum_q <= '0;
        else if (data_xfer) csum_q <= csum_q ^ rx_data_i;
    end
`endif

    assign mem_wr_byte_en_o = word_vld ? WR_EN_ALL : 4'h0;
    assign mem_addr_o       = addr_q;
    assign mem_wr_data_o    = word;
    assign done_o           = (state_q == ST_DONE);
    assign core_resetn_o    = (state_q == ST_DONE);
    assign error_o          = (state_q == ST_ERR);

endmodule

// File: tb/tb_toast_boot_loader.sv
// Directed frames for the boot loader; writes are checked against a queue of expected (addr, data).
// Builds with or without TOAST_LOADER_CHECKSUM_EN; frames append the checksum byte when enabled.
module tb_toast_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk;
    logic        resetn_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [3:0]  mem_wr_byte_en_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wr_data_o;
    logic        core_resetn_o;
    logic        done_o;
    logic        error_o;

    toast_boot_loader #(.MEM_DEPTH(4096), .LOAD_BASE(BASE)) dut (
        .clk_i            (clk),
        .resetn_i         (resetn_i),
        .rx_data_i        (rx_data_i),
        .rx_valid_i       (rx_valid_i),
        .rx_ready_o       (rx_ready_o),
        .mem_wr_byte_en_o (mem_wr_byte_en_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wr_data_o    (mem_wr_data_o),
        .core_resetn_o    (core_resetn_o),
        .done_o           (done_o),
        .error_o          (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    int         checks   = 0;
    int         failures = 0;
    int         word_cnt = 0;
    logic [7:0] run_csum = 8'h00;
    logic       mon_en   = 1'b0;
    logic       prev_strobe = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected write and last exactly one cycle.
    always @(negedge clk) begin
        if (mon_en && (mem_wr_byte_en_o !== 4'h0)) begin
            chk("wr_byte_en", {28'd0, mem_wr_byte_en_o}, 32'hF);
            chk("wr_single_cycle", {31'd0, prev_strobe}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=0x%08h data=0x%08h required none",
                         mem_addr_o, mem_wr_data_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", mem_addr_o, mon_e.addr);
                chk("wr_data", mem_wr_data_o, mon_e.data);
            end
        end
        prev_strobe <= (mem_wr_byte_en_o !== 4'h0);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One byte offered for exactly one cycle; data goes to junk afterwards.
    task automatic send(input logic [7:0] b, input bit gap);
        if (gap) idle(1);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(posedge clk);
        #1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'hFF;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        wr_t e;
        for (int i = 0; i < 4; i++) begin
            send(w[8*i +: 8], gap);
            run_csum = run_csum ^ w[8*i +: 8];
        end
        e.addr = BASE + 32'(word_cnt) * 32'd4;
        e.data = w;
        exp_q.push_back(e);
        word_cnt++;
    endtask

    task automatic do_reset();
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        resetn_i   = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        chk("rst_rx_ready",    {31'd0, rx_ready_o},       32'd1);
        chk("rst_byte_en",     {28'd0, mem_wr_byte_en_o}, 32'd0);
        chk("rst_addr",        mem_addr_o,                32'd0);
        chk("rst_data",        mem_wr_data_o,             32'd0);
        chk("rst_core_resetn", {31'd0, core_resetn_o},    32'd0);
        chk("rst_done",        {31'd0, done_o},           32'd0);
        chk("rst_error",       {31'd0, error_o},          32'd0);
        resetn_i = 1'b1;
        word_cnt = 0;
        run_csum = 8'h00;
    endtask

    task automatic check_status(input string name, input bit exp_done, input bit exp_err);
        chk({name, "_done"},        {31'd0, done_o},        {31'd0, exp_done});
        chk({name, "_core_resetn"}, {31'd0, core_resetn_o}, {31'd0, exp_done});
        chk({name, "_error"},       {31'd0, error_o},       {31'd0, exp_err});
        chk({name, "_rx_ready"},    {31'd0, rx_ready_o},    {31'd0, !(exp_done || exp_err)});
    endtask

    task automatic drain(input string name);
        idle(3);
        chk({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        resetn_i   = 1'b0;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;

        // N=2 image, streamed back to back.
        do_reset();
        send(8'h02, 0); send(8'h00, 0);
        send_word(32'h0000_0513, 0);
        send_word(32'h0010_0093, 0);
`ifdef TOAST_LOADER_CHECKSUM_EN
        check_status("n2_before_csum", 0, 0);
        send(8'h95, 0);
`endif
        check_status("n2", 1, 0);
        idle(2);
        check_status("n2_hold", 1, 0);
        drain("n2");

`ifdef TOAST_LOADER_CHECKSUM_EN
        // Same image with a wrong checksum byte.
        do_reset();
        send(8'h02, 0); send(8'h00, 0);
        send_word(32'h0000_0513, 0);
        send_word(32'h0010_0093, 0);
        send(8'h00, 0);
        check_status("bad_csum", 0, 1);
        drain("bad_csum");
`endif

        // Length one beyond memory depth.
        do_reset();
        send(8'h01, 0); send(8'h10, 0);
        check_status("too_long", 0, 1);
        send(8'h13, 0); send(8'h05, 0); send(8'h00, 0); send(8'h00, 0);
        check_status("too_long_hold", 0, 1);
        drain("too_long");

        // Empty image.
        do_reset();
        send(8'h00, 0); send(8'h00, 0);
`ifdef TOAST_LOADER_CHECKSUM_EN
        check_status("n0_before_csum", 0, 0);
        send(8'h00, 0);
`endif
        check_status("n0", 1, 0);
        drain("n0");

        // N=3 with valid toggling every other cycle and junk on idle cycles.
        do_reset();
        send(8'h03, 1); send(8'h00, 1);
        send_word(32'h1122_3344, 1);
        send_word(32'hDEAD_BEEF, 1);
        send_word(32'h0000_0001, 1);
`ifdef TOAST_LOADER_CHECKSUM_EN
        send(run_csum, 1);
`endif
        check_status("n3_gap", 1, 0);
        drain("n3_gap");

        // Reset after six data bytes, then a fresh N=1 frame.
        do_reset();
        send(8'h02, 0); send(8'h00, 0);
        send_word(32'hDDCC_BBAA, 0);
        send(8'h11, 0); send(8'h22, 0);
        idle(1);
        do_reset();
        drain("mid_reset");
        send(8'h01, 0); send(8'h00, 0);
        send_word(32'h1234_5678, 0);
`ifdef TOAST_LOADER_CHECKSUM_EN
        send(8'h08, 0);
`endif
        check_status("after_reset", 1, 0);
        drain("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/toast_boot_loader.md
# toast_boot_loader

Byte-stream program loader that sits upstream of the core: it takes a framed little-endian image from a byte source (UART receiver or bench driver), packs it into 32-bit words, and writes them into the unified instruction/data memory through a byte-enabled write port. It holds the core in reset until the image is fully loaded, and verified when checksum is enabled, then releases it. On a bad frame it reports an error.

## Interface
- `MEM_DEPTH`, 4096: memory size in 32-bit words; the image word-count limit.
- `LOAD_BASE`, 32'h0000_0000: byte address of the first word written; must be 4-byte aligned.
- `clk_i` in 1: clock.
- `resetn_i` in 1: reset, synchronous, active-low.
- `rx_data_i` in 8: stream byte.
- `rx_valid_i` in 1: `rx_data_i` valid.
- `rx_ready_o` out 1: loader accepts a byte. A byte transfers when valid & ready are both high at a rising edge.
- `mem_wr_byte_en_o` out 4: write byte enables, 4'hF during a write, else 4'h0.
- `mem_addr_o` out 32: write byte address.
- `mem_wr_data_o` out 32: write word.
- `core_resetn_o` out 1: core reset, low until DONE.
- `done_o` out 1: image loaded.
- `error_o` out 1: frame error.

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4·N data bytes (each word LSB first), then one CSUM byte (only with checksum enabled).
- FSM states: LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR. Reset enters LEN_LO.
- LEN_LO -> LEN_HI on a transfer.
- LEN_HI -> DATA on a transfer, with these exceptions:
  - N > MEM_DEPTH: go to ERR.
  - N == 0: go to CSUM, or to DONE when checksum is disabled.
- DATA: a byte counter (0..3) packs bytes into bits [8k+7:8k].
  - On the 4th byte, the assembled word is written.
  - The word index increments.
  - After word N-1, go to CSUM, or to DONE when checksum is disabled.
- CSUM: running XOR of all data bytes (length bytes excluded) is compared to the received byte.
  - Equal: go to DONE.
  - Not equal: go to ERR.
- DONE and ERR are terminal. Only `resetn_i` leaves them.
- Address of word i: LOAD_BASE + 4·i, 32-bit wrap.

## Timing
- Reset values (registered outputs):
  - `rx_ready_o`=1.
  - `mem_wr_byte_en_o`=0, `mem_addr_o`=0, `mem_wr_data_o`=0.
  - `core_resetn_o`=0, `done_o`=0, `error_o`=0.
- `rx_ready_o` is 1 in LEN_LO/LEN_HI/DATA/CSUM and 0 in DONE/ERR. There are no bubbles; one byte per cycle is sustained.
- Write latency: the memory write strobe is high for exactly the one cycle after the 4th byte of a word transfers. Address and data are valid in that same cycle.
- A write may overlap acceptance of the next word's first byte.
- `done_o`, `core_resetn_o` rise together in the first cycle in DONE:
  - checksum enabled: the cycle after the CSUM byte transfers;
  - checksum disabled: the cycle after the last data byte transfers, which is the same cycle as the final write strobe.
- `error_o` rises in the first cycle in ERR. `core_resetn_o` stays 0 in ERR.
- `resetn_i` low mid-frame: the cycle after the reset edge, all outputs are at reset values. Partial word and counters are discarded; no write is issued.
- `rx_valid_i` low: state and counters hold.

## Configuration
- `TOAST_LOADER_CHECKSUM_EN` defined:
  - CSUM state, XOR accumulator and compare are present.
  - The frame ends with the CSUM byte.
- `TOAST_LOADER_CHECKSUM_EN` undefined:
  - CSUM and the accumulator are absent.
  - Frame ends after the last data byte; ERR is reachable only via the length check.

## Structure
- Shared package `toast_loader_pkg`:
  - FSM state enum.
  - Byte-lane count (4).
  - Length field width (16).
  - Write-enable constant 4'hF.
- Sub-module `toast_byte_packer`:
  - Lane counter plus 32-bit shift/assemble register.
  - Emits word-valid pulse and word.
  - Cleared by reset.
- Top holds FSM, word index, address adder, checksum, outputs.

## Test plan
- N=2, bytes 13 05 00 00 / 93 00 10 00, CSUM=0x95 (checksum on) -> writes 0x00000513 @0x0, then 0x00100093 @0x4. DONE after CSUM; `core_resetn_o`=1, `error_o`=0.
- Same image with CSUM=0x00 -> no further writes after data; ERR; `error_o`=1, `core_resetn_o`=0, `rx_ready_o`=0.
- N=0x1001 with MEM_DEPTH=4096 -> ERR the cycle after LEN_HI; zero writes.
- N=0, checksum off -> DONE the cycle after LEN_HI; zero writes.
- N=3 with `rx_valid_i` toggled every other cycle -> same three words at 0x0/0x4/0x8; each write strobe lasts one cycle.
- `resetn_i` low after 6 data bytes -> one write only; outputs at reset values. The bench then resends a fresh full N=1 frame -> the word is written at LOAD_BASE.
